clk_div_bank: RTL and testbench

Parametrised multi-channel clock/tick generator that replaces fixed-ratio divider blocks in the 50 MHz domain. Each of CH channels divides clk_50MHz by its own divisor, which is runtime-programmable, and produces a near-50% duty divided clock plus a one-cycle tick strobe. Divisor changes are staged and applied only at a period boundary, so the output never glitches. Downstream consumers are the display scan, debounce, and CPU single-step/slow-clock logic.

---
 rtl/clk_div_bank.sv | 121 ++++++++++++
 tb/tb_clk_div_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of CH programmable clock dividers in the clk_50MHz domain.
// Each channel divides clk_50MHz by its own runtime divisor. It produces a
// near-50% duty clock (odd divisors give the extra cycle to the high phase)
// and a one-cycle tick at each rising edge of that clock. New divisors are
// staged and only take effect at a period boundary, or right away when the
// channel is stopped, so a running output never gets a short or long period.
//
// Ports:
//   clk_50MHz      system clock, rising edge
//   rst            synchronous, active-low reset
//   en[CH]         per-channel run enable
//   wr_en          divisor write strobe
//   wr_ch[4]       target channel; writes with wr_ch >= CH are dropped
//   wr_div[W]      new divisor, unsigned
//   clk_out[CH]    divided clocks, registered
//   tick[CH]       one-cycle strobe coincident with the first high cycle
//   pend[CH]       staged divisor not yet applied

// One divider channel.
module clk_div_chan #(
    parameter int W       = 32,
    parameter int DEF_DIV = 50
) (
    input  logic         clk_50MHz,
    input  logic         rst,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wr_div,
    output logic         clk_out,
    output logic         tick,
    output logic         pend
);
    logic [W-1:0] d;     // active divisor
    logic [W-1:0] s;     // staged divisor
    logic [W-1:0] cnt;
    logic [W-1:0] half;  // ceil(d/2): length of the high phase
    logic         running;
    logic         wrap;

    assign half    = d - (d >> 1);
    assign running = en && (d >= W'(2));
    // d >= 2 whenever this is used, so d-1 cannot underflow.
    assign wrap    = (cnt == d - W'(1));

    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            d       <= W'(DEF_DIV);
            s       <= W'(DEF_DIV);
            cnt     <= '0;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (running) begin
                clk_out <= (cnt < half);
                tick    <= (cnt == '0);
                if (wrap) begin
                    cnt <= '0;
                    if (pend) begin
                        d    <= s;
                        pend <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + W'(1);
                end
            end else begin
                // Stopped: hold at the start of a period so a restart
                // begins with a full high phase and a tick.
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend) begin
                    d    <= s;
                    pend <= 1'b0;
                end
            end
            // A write on the apply edge wins: it re-arms pend, so the fresh
            // value is picked up at the following boundary.
            if (wr) begin
                s    <= wr_div;
                pend <= 1'b1;
            end
        end
    end
endmodule

module clk_div_bank #(
    parameter int CH      = 4,
    parameter int W       = 32,
    parameter int DEF_DIV = 50
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    input  logic [CH-1:0] en,
    input  logic          wr_en,
    input  logic [3:0]    wr_ch,
    input  logic [W-1:0]  wr_div,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] pend
);
    // Channel index never reaches CH, so out-of-range wr_ch decodes to nothing.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic wr;
        assign wr = wr_en && (wr_ch == 4'(i));

        clk_div_chan #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_50MHz (clk_50MHz),
            .rst       (rst),
            .en        (en[i]),
            .wr        (wr),
            .wr_div    (wr_div),
            .clk_out   (clk_out[i]),
            .tick      (tick[i]),
            .pend      (pend[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (CH=4, W=32, DEF_DIV=50).
// Outputs are sampled 1 time unit after each rising edge. A "period" is
// measured from one tick sample to the next.
module tb_clk_div_bank;
    localparam int CH = 4;
    localparam int W  = 32;

    logic          clk_50MHz;
    logic          rst;
    logic [CH-1:0] en;
    logic          wr_en;
    logic [3:0]    wr_ch;
    logic [W-1:0]  wr_div;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] pend;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_bank #(.CH(CH), .W(W), .DEF_DIV(50)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .pend      (pend)
    );

    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    // One write-and-measure record: a write of d1 (and d2 on the next cycle
    // when d2 != 0) lands wr_at cycles into a period; the expected shape of
    // that period and of the next one follow.
    typedef struct {
        int ch;
        int wr_at;
        int d1;
        int d2;
        int old_hi;
        int old_lo;
        int pcnt;
        int new_hi;
        int new_lo;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic wait_tick(input int ch);
        int k = 0;
        while (!tick[ch] && k < 400) begin
            step();
            k++;
        end
        if (!tick[ch]) chk("wait_tick_timeout", 0, 1);
    endtask

    // Measures one period of channel ch, optionally issuing writes inside it.
    task automatic measure(input int ch, input int wr_at, input int d1, input int d2,
                           output int hi, output int lo, output int tk, output int pc);
        int n = 0;
        hi = 0; lo = 0; tk = 0; pc = 0;
        wait_tick(ch);
        do begin
            if (clk_out[ch]) hi++; else lo++;
            if (tick[ch]) tk++;
            if (pend[ch]) pc++;
            if (n == wr_at) begin
                wr_en = 1'b1; wr_ch = 4'(ch); wr_div = W'(d1);
            end else if (d2 != 0 && n == wr_at + 1) begin
                wr_en = 1'b1; wr_ch = 4'(ch); wr_div = W'(d2);
            end
            step();
            wr_en = 1'b0;
            n++;
        end while (!tick[ch] && n < 400);
        if (n >= 400) chk("measure_timeout", 0, 1);
    endtask

    initial begin
        int hi, lo, tk, pc, k, bad;

        //            ch wr_at d1  d2 ohi olo pc nhi nlo
        vecs[0] = '{1, 10,   5,  0, 25, 25, 38, 3,  2};
        vecs[1] = '{3, 5,    10, 20, 25, 25, 43, 10, 10};
        vecs[2] = '{1, 1,    7,  0, 3,  2,  2,  4,  3};
        vecs[3] = '{1, 2,    5,  0, 4,  3,  3,  3,  2};

        rst = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        repeat (3) step();
        // Reset overrides enable and writes.
        en = '1; wr_en = 1'b1; wr_ch = 4'd0; wr_div = 32'd7;
        step();
        wr_en = 1'b0;
        step();
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_pend", int'(pend), 0);

        // First edge after release: cnt=0, so every channel starts high with a tick.
        rst = 1'b1;
        step();
        chk("release_tick", int'(tick), 15);
        chk("release_clk_out", int'(clk_out), 15);

        measure(0, -1, 0, 0, hi, lo, tk, pc);
        chk("def_hi", hi, 25);
        chk("def_lo", lo, 25);
        chk("def_ticks", tk, 1);

        foreach (vecs[i]) begin
            measure(vecs[i].ch, vecs[i].wr_at, vecs[i].d1, vecs[i].d2, hi, lo, tk, pc);
            chk($sformatf("v%0d_old_hi", i), hi, vecs[i].old_hi);
            chk($sformatf("v%0d_old_lo", i), lo, vecs[i].old_lo);
            chk($sformatf("v%0d_pend_cycles", i), pc, vecs[i].pcnt);
            measure(vecs[i].ch, -1, 0, 0, hi, lo, tk, pc);
            chk($sformatf("v%0d_new_hi", i), hi, vecs[i].new_hi);
            chk($sformatf("v%0d_new_lo", i), lo, vecs[i].new_lo);
            chk($sformatf("v%0d_new_ticks", i), tk, 1);
        end

        // Untouched channels keep their default period.
        measure(0, -1, 0, 0, hi, lo, tk, pc);
        chk("undist_ch0", hi * 100 + lo, 2525);
        measure(2, -1, 0, 0, hi, lo, tk, pc);
        chk("undist_ch2", hi * 100 + lo, 2525);

        // Write of 4 to ch2 on its cnt==49 edge: one more 50-cycle period first.
        measure(2, 48, 4, 0, hi, lo, tk, pc);
        chk("wrapwr_p0", hi * 100 + lo, 2525);
        chk("wrapwr_p0_pend", pc, 1);
        measure(2, -1, 0, 0, hi, lo, tk, pc);
        chk("wrapwr_p1", hi * 100 + lo, 2525);
        chk("wrapwr_p1_pend", pc, 49);
        measure(2, -1, 0, 0, hi, lo, tk, pc);
        chk("wrapwr_p2", hi * 100 + lo, 202);

        // Divisor 1 on ch0 stops it; divisor 8 then applies on the next edge.
        wait_tick(0);
        repeat (5) step();
        wr_en = 1'b1; wr_ch = 4'd0; wr_div = 32'd1;
        step();
        wr_en = 1'b0;
        k = 0;
        while (pend[0] && k < 100) begin
            step();
            k++;
        end
        chk("div1_apply_delay", k, 43);
        bad = 0;
        repeat (6) begin
            if (clk_out[0] || tick[0]) bad++;
            step();
        end
        chk("div1_stopped", bad, 0);
        wr_en = 1'b1; wr_ch = 4'd0; wr_div = 32'd8;
        step();
        wr_en = 1'b0;
        chk("div8_pend_set", int'(pend[0]), 1);
        step();
        chk("div8_pend_clr", int'(pend[0]), 0);
        chk("div8_still_low", int'(clk_out[0]), 0);
        step();
        chk("div8_first_tick", int'(tick[0]), 1);
        measure(0, -1, 0, 0, hi, lo, tk, pc);
        chk("div8_period", hi * 100 + lo, 404);
        chk("div8_ticks", tk, 1);

        // en[1] dropped during the high phase, low for 7 edges, then raised.
        wait_tick(1);
        en[1] = 1'b0;
        step();
        chk("en_drop_clk", int'(clk_out[1]), 0);
        bad = 0;
        repeat (6) begin
            if (clk_out[1] || tick[1]) bad++;
            step();
        end
        chk("en_low_quiet", bad, 0);
        en[1] = 1'b1;
        step();
        chk("en_restart_tick", int'(tick[1]), 1);
        chk("en_restart_clk", int'(clk_out[1]), 1);
        measure(1, -1, 0, 0, hi, lo, tk, pc);
        chk("en_restart_period", hi * 100 + lo, 302);

        // Out-of-range channel index is ignored.
        wr_en = 1'b1; wr_ch = 4'd12; wr_div = 32'd3;
        step();
        wr_en = 1'b0;
        step();
        chk("bad_ch_pend", int'(pend), 0);

        // Reset mid-period discards a staged divisor and restores the default.
        wr_en = 1'b1; wr_ch = 4'd0; wr_div = 32'd3;
        step();
        wr_en = 1'b0;
        rst = 1'b0;
        step();
        chk("midrst_clk_out", int'(clk_out), 0);
        chk("midrst_pend", int'(pend), 0);
        rst = 1'b1;
        step();
        measure(0, -1, 0, 0, hi, lo, tk, pc);
        chk("midrst_period", hi * 100 + lo, 2525);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
